id_stage_pipe: RTL and testbench

Parametrised, registered instruction-decode stage with an ID/EX pipeline register. It combines the register file, the control decoder and the immediate extender, and adds three things the original decode stage lacks: a valid/ready handshake, load-use hazard stalling with bubble insertion, and flush. It sits between the IF/ID register and the EX stage. Write-back writes arrive from the WB stage.

---
 rtl/id_pkg.sv | 82 ++++++++
 rtl/id_stage_pipe_if.sv | 63 ++++++
 rtl/id_regfile.sv | 53 +++++
 rtl/id_stage_pipe.sv | 161 ++++++++++++++++
 tb/tb_id_stage_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg : shared definitions for the instruction-decode stage.
//   - MIPS opcode / funct field values recognised by the decoder
//   - alu_src_e : ALU second-operand select (SRC_RT, SRC_IMM, SRC_SHAMT)
//   - id_ctl_t  : control bundle carried through the ID/EX register
//   - decode_ctl: opcode/funct -> control bundle
// -----------------------------------------------------------------------------
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;

    typedef enum logic [1:0] {
        SRC_RT    = 2'd0,
        SRC_IMM   = 2'd1,
        SRC_SHAMT = 2'd2
    } alu_src_e;

    typedef struct packed {
        logic     reg_write;
        logic     mem_read;
        logic     mem_write;
        logic     mem_to_reg;
        logic     branch;
        logic     branch_ne;
        alu_src_e alu_src;
        logic     illegal;
    } id_ctl_t;

    // Unknown opcodes decode to a NOP with only the illegal flag raised.
    function automatic id_ctl_t decode_ctl(input logic [5:0] opcode,
                                           input logic [5:0] funct);
        id_ctl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                if (funct inside {FN_SLL, FN_SRL, FN_SRA}) begin
                    c.alu_src = SRC_SHAMT;
                end
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: begin
                c.reg_write = 1'b1;
                c.alu_src   = SRC_IMM;
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = SRC_IMM;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = SRC_IMM;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
            end
            OP_BNE: begin
                c.branch    = 1'b1;
                c.branch_ne = 1'b1;
            end
            default: begin
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// -----------------------------------------------------------------------------
// id_stage_pipe_if : handshake and data bundle of the decode stage.
//   Upstream side   : in_valid, in_ready, Instruction, Flush
//   Write-back side : RegWrite_WB, WriteRegister_IN, WriteData
//   EX side         : out_valid, out_ready, ReadData1/2, Immediate_Extended,
//                     Rs, Rt, Rd, Shamt, control flags, ALUSrc, ALUOp,
//                     Illegal, StallCount
//   master : drives instructions / write-back / out_ready (environment)
//   slave  : the decode stage itself
// -----------------------------------------------------------------------------
interface id_stage_pipe_if
    import id_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_N       = 32,
    parameter int STALL_CNT_W = 16
);
    localparam int AW = $clog2(REG_N);

    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            Instruction;
    logic                   RegWrite_WB;
    logic [AW-1:0]          WriteRegister_IN;
    logic [DATA_W-1:0]      WriteData;
    logic                   Flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      ReadData1;
    logic [DATA_W-1:0]      ReadData2;
    logic [DATA_W-1:0]      Immediate_Extended;
    logic [AW-1:0]          Rs;
    logic [AW-1:0]          Rt;
    logic [AW-1:0]          Rd;
    logic [4:0]             Shamt;
    logic                   RegWrite;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   MemtoReg;
    logic                   Branch;
    logic                   BranchNe;
    logic [1:0]             ALUSrc;
    logic [5:0]             ALUOp;
    logic                   Illegal;
    logic [STALL_CNT_W-1:0] StallCount;

    modport master (
        output in_valid, Instruction, RegWrite_WB, WriteRegister_IN, WriteData,
               Flush, out_ready,
        input  in_ready, out_valid, ReadData1, ReadData2, Immediate_Extended,
               Rs, Rt, Rd, Shamt, RegWrite, MemRead, MemWrite, MemtoReg,
               Branch, BranchNe, ALUSrc, ALUOp, Illegal, StallCount
    );

    modport slave (
        input  in_valid, Instruction, RegWrite_WB, WriteRegister_IN, WriteData,
               Flush, out_ready,
        output in_ready, out_valid, ReadData1, ReadData2, Immediate_Extended,
               Rs, Rt, Rd, Shamt, RegWrite, MemRead, MemWrite, MemtoReg,
               Branch, BranchNe, ALUSrc, ALUOp, Illegal, StallCount
    );

endinterface

// File: rtl/id_regfile.sv
// -----------------------------------------------------------------------------
// id_regfile : REG_N x DATA_W register file, two combinational read ports,
// one write port. Register 0 reads as zero and ignores writes. Synchronous
// active-low reset clears every register.
//   Clk, Rst           : clock, synchronous active-low reset
//   raddr1_i/raddr2_i  : read addresses      rdata1_o/rdata2_o : read data
//   we_i/waddr_i/wdata_i : write-back port
// Optional: ID_WB_BYPASS_EN forwards a same-cycle write to a matching read.
// -----------------------------------------------------------------------------
module id_regfile
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [$clog2(REG_N)-1:0]   raddr1_i,
    input  logic [$clog2(REG_N)-1:0]   raddr2_i,
    input  logic                       we_i,
    input  logic [$clog2(REG_N)-1:0]   waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata1_o,
    output logic [DATA_W-1:0]          rdata2_o
);
    localparam int AW = $clog2(REG_N);

    logic [DATA_W-1:0] mem_q [REG_N];

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                mem_q[i[AW-1:0]] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
        rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];
`ifdef ID_WB_BYPASS_EN
        if (we_i && (waddr_i != '0) && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        if (we_i && (waddr_i != '0) && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
`endif
    end

endmodule

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe : registered MIPS decode stage with ID/EX pipeline register.
//   Clk : clock            Rst : synchronous active-low reset
//   bus : id_stage_pipe_if.slave (instruction handshake, write-back port,
//         EX-side outputs, StallCount)
// Adds valid/ready handshake, load-use stall with a single bubble, flush,
// and a saturating stall-cycle counter.
// Optional: ID_WB_BYPASS_EN (same-cycle write-back forwarding in id_regfile).
// -----------------------------------------------------------------------------
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_N       = 32,
    parameter int STALL_CNT_W = 16
) (
    input logic           Clk,
    input logic           Rst,
    id_stage_pipe_if.slave bus
);
    localparam int AW = $clog2(REG_N);

    // Instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [AW-1:0] rd_addr;

    assign opcode  = bus.Instruction[31:26];
    assign funct   = bus.Instruction[5:0];
    assign imm16   = bus.Instruction[15:0];
    assign shamt   = bus.Instruction[10:6];
    assign rs_addr = bus.Instruction[21 +: AW];
    assign rt_addr = bus.Instruction[16 +: AW];
    assign rd_addr = bus.Instruction[11 +: AW];

    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    id_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .Clk      (Clk),
        .Rst      (Rst),
        .raddr1_i (rs_addr),
        .raddr2_i (rt_addr),
        .we_i     (bus.RegWrite_WB),
        .waddr_i  (bus.WriteRegister_IN),
        .wdata_i  (bus.WriteData),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    // Decode (next-state values for the ID/EX register)
    id_ctl_t           ctl_d;
    logic [DATA_W-1:0] imm_d;
    logic [AW-1:0]     dest_d;
    logic [5:0]        aluop_d;
    logic              uses_rt;
    logic              zero_ext;
    logic              is_rtype;

    always_comb begin
        ctl_d    = decode_ctl(opcode, funct);
        is_rtype = (opcode == OP_RTYPE);
        zero_ext = opcode inside {OP_ANDI, OP_ORI, OP_LUI};
        uses_rt  = opcode inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};
        imm_d    = zero_ext ? {{(DATA_W-16){1'b0}}, imm16}
                            : {{(DATA_W-16){imm16[15]}}, imm16};
        dest_d   = is_rtype ? rd_addr : rt_addr;
        aluop_d  = is_rtype ? funct : opcode;
    end

    // ID/EX register
    logic                   out_valid_q;
    id_ctl_t                ctl_q;
    logic [DATA_W-1:0]      rd1_q;
    logic [DATA_W-1:0]      rd2_q;
    logic [DATA_W-1:0]      imm_q;
    logic [AW-1:0]          rs_q;
    logic [AW-1:0]          rt_q;
    logic [AW-1:0]          dest_q;
    logic [4:0]             shamt_q;
    logic [5:0]             aluop_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    // Load-use: the load currently in ID/EX targets a source of the incoming
    // instruction, so the consumer must wait one cycle behind a bubble.
    logic hazard;
    logic advance;

    assign hazard = bus.in_valid && out_valid_q && ctl_q.mem_read &&
                    (dest_q != '0) &&
                    ((dest_q == rs_addr) || (uses_rt && (dest_q == rt_addr)));
    assign advance = !out_valid_q || bus.out_ready;

    assign stall_cnt_d = (hazard && (stall_cnt_q != '1))
                       ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            out_valid_q <= 1'b0;
            ctl_q       <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            dest_q      <= '0;
            shamt_q     <= '0;
            aluop_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (bus.Flush) begin
                out_valid_q <= 1'b0;
            end else if (advance) begin
                if (hazard) begin
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= bus.in_valid;
                    ctl_q       <= ctl_d;
                    rd1_q       <= rdata1;
                    rd2_q       <= rdata2;
                    imm_q       <= imm_d;
                    rs_q        <= rs_addr;
                    rt_q        <= rt_addr;
                    dest_q      <= dest_d;
                    shamt_q     <= shamt;
                    aluop_q     <= aluop_d;
                end
            end
        end
    end

    assign bus.in_ready           = Rst && advance && !hazard;
    assign bus.out_valid          = out_valid_q;
    assign bus.ReadData1          = rd1_q;
    assign bus.ReadData2          = rd2_q;
    assign bus.Immediate_Extended = imm_q;
    assign bus.Rs                 = rs_q;
    assign bus.Rt                 = rt_q;
    assign bus.Rd                 = dest_q;
    assign bus.Shamt              = shamt_q;
    assign bus.RegWrite           = ctl_q.reg_write;
    assign bus.MemRead            = ctl_q.mem_read;
    assign bus.MemWrite           = ctl_q.mem_write;
    assign bus.MemtoReg           = ctl_q.mem_to_reg;
    assign bus.Branch             = ctl_q.branch;
    assign bus.BranchNe           = ctl_q.branch_ne;
    assign bus.ALUSrc             = ctl_q.alu_src;
    assign bus.ALUOp              = aluop_q;
    assign bus.Illegal            = ctl_q.illegal;
    assign bus.StallCount         = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe : self-checking bench for id_stage_pipe.
// Directed vector table, multi-cycle corner sequences and a randomized phase,
// all checked every cycle against a transaction-level reference model.
// Honors ID_WB_BYPASS_EN for the expected same-cycle read value.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

    localparam int DATA_W      = 32;
    localparam int REG_N       = 32;
    localparam int STALL_CNT_W = 16;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    id_stage_pipe_if #(.DATA_W(DATA_W), .REG_N(REG_N), .STALL_CNT_W(STALL_CNT_W)) bus ();

    id_stage_pipe #(.DATA_W(DATA_W), .REG_N(REG_N), .STALL_CNT_W(STALL_CNT_W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        br;
        logic        bne;
        logic [1:0]  src;
        logic [5:0]  aluop;
        logic        ill;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [5:0]  aluop;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [1:0]  src;
        logic        ill;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus for the next cycle
    logic        s_rst, s_iv, s_we, s_flush, s_ordy;
    logic [31:0] s_instr, s_wd;
    logic [4:0]  s_wa;
    int          d_ready_exp = -1;

    // Reference model state
    logic [31:0] m_regs [32];
    obs_t        m_out;
    logic [15:0] m_cnt;

    task automatic chk(input string nm, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (s_we && (s_wa == a)) return s_wd;
`endif
        return m_regs[a];
    endfunction

    function automatic obs_t ref_decode(input logic [31:0] ins);
        obs_t o;
        logic [5:0] op, fn;
        logic [15:0] im;
        o  = '0;
        op = ins[31:26];
        fn = ins[5:0];
        im = ins[15:0];
        o.valid = 1'b1;
        o.rd1   = ref_read(ins[25:21]);
        o.rd2   = ref_read(ins[20:16]);
        o.rs    = ins[25:21];
        o.rt    = ins[20:16];
        o.shamt = ins[10:6];
        o.rd    = (op == 6'h00) ? ins[15:11] : ins[20:16];
        o.aluop = (op == 6'h00) ? fn : op;
        o.imm   = (op == 6'h0C || op == 6'h0D || op == 6'h0F) ? {16'h0, im} : {{16{im[15]}}, im};
        case (op)
            6'h00: begin o.rw = 1'b1; o.src = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd2 : 2'd0; end
            6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F: begin o.rw = 1'b1; o.src = 2'd1; end
            6'h23: begin o.rw = 1'b1; o.mr = 1'b1; o.m2r = 1'b1; o.src = 2'd1; end
            6'h2B: begin o.mw = 1'b1; o.src = 2'd1; end
            6'h04: o.br = 1'b1;
            6'h05: begin o.br = 1'b1; o.bne = 1'b1; end
            default: o.ill = 1'b1;
        endcase
        return o;
    endfunction

    function automatic logic model_hazard();
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic urt;
        op  = s_instr[31:26];
        rs  = s_instr[25:21];
        rt  = s_instr[20:16];
        urt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        return s_iv && m_out.valid && m_out.mr && (m_out.rd != 5'd0) &&
               ((m_out.rd == rs) || (urt && (m_out.rd == rt)));
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.valid = bus.out_valid;   o.rd1 = bus.ReadData1;   o.rd2 = bus.ReadData2;
        o.imm   = bus.Immediate_Extended;
        o.rs    = bus.Rs;          o.rt  = bus.Rt;          o.rd  = bus.Rd;
        o.shamt = bus.Shamt;       o.rw  = bus.RegWrite;    o.mr  = bus.MemRead;
        o.mw    = bus.MemWrite;    o.m2r = bus.MemtoReg;    o.br  = bus.Branch;
        o.bne   = bus.BranchNe;    o.src = bus.ALUSrc;      o.aluop = bus.ALUOp;
        o.ill   = bus.Illegal;
        return o;
    endfunction

    // One clock: drive, check in_ready, clock edge, advance model, check outputs.
    task automatic cycle();
        logic hz, exp_ready;
        obs_t dec, got;
        @(negedge Clk);
        Rst                  = s_rst;
        bus.in_valid         = s_iv;
        bus.Instruction      = s_instr;
        bus.RegWrite_WB      = s_we;
        bus.WriteRegister_IN = s_wa;
        bus.WriteData        = s_wd;
        bus.Flush            = s_flush;
        bus.out_ready        = s_ordy;
        #1;
        hz        = model_hazard();
        exp_ready = s_rst && (!m_out.valid || s_ordy) && !hz;
        chk("in_ready", {135'd0, bus.in_ready}, {135'd0, exp_ready});
        if (d_ready_exp >= 0) chk("dir_in_ready", {135'd0, bus.in_ready}, 136'(d_ready_exp));
        d_ready_exp = -1;
        dec = ref_decode(s_instr);
        @(posedge Clk);
        if (!s_rst) begin
            m_out = '0;
            m_cnt = '0;
            foreach (m_regs[i]) m_regs[i] = '0;
        end else begin
            if (hz && m_cnt != 16'hFFFF) m_cnt++;
            if (s_flush) m_out.valid = 1'b0;
            else if (!m_out.valid || s_ordy) begin
                if (hz) m_out.valid = 1'b0;
                else begin
                    m_out       = dec;
                    m_out.valid = s_iv;
                end
            end
            if (s_we && s_wa != 5'd0) m_regs[s_wa] = s_wd;
        end
        #1;
        got = sample();
        if (m_out.valid || !s_rst) chk("outputs", 136'(got), 136'(m_out));
        else                       chk("out_valid", {135'd0, got.valid}, 136'd0);
        chk("StallCount", 136'(bus.StallCount), 136'(m_cnt));
    endtask

    task automatic set_idle();
        s_rst = 1'b1; s_iv = 1'b0; s_we = 1'b0; s_flush = 1'b0; s_ordy = 1'b1;
        s_instr = 32'h0; s_wd = 32'h0; s_wa = 5'd0;
    endtask

    vec_t        vt [7];
    logic [5:0]  ops [11];
    logic [5:0]  fns [7];

    initial begin
        Rst = 1'b0;
        bus.in_valid = 1'b0; bus.Instruction = '0; bus.RegWrite_WB = 1'b0;
        bus.WriteRegister_IN = '0; bus.WriteData = '0; bus.Flush = 1'b0; bus.out_ready = 1'b0;
        m_out = '0; m_cnt = '0;
        foreach (m_regs[i]) m_regs[i] = '0;

        //             instr          rd1          imm          rd  aluop  rw mr mw src ill
        vt[0] = '{32'h00A00820, 32'h1234, 32'h00000820, 5'd1, 6'h20, 1, 0, 0, 2'd0, 0}; // add r1,r5,r0
        vt[1] = '{32'h2002FFFF, 32'h0,    32'hFFFFFFFF, 5'd2, 6'h08, 1, 0, 0, 2'd1, 0}; // addi r2,r0,-1
        vt[2] = '{32'h3402FFFF, 32'h0,    32'h0000FFFF, 5'd2, 6'h0D, 1, 0, 0, 2'd1, 0}; // ori r2,r0,0xFFFF
        vt[3] = '{32'hFCA00000, 32'h1234, 32'h00000000, 5'd0, 6'h3F, 0, 0, 0, 2'd0, 1}; // illegal 0x3F
        vt[4] = '{32'h00050900, 32'h0,    32'h00000900, 5'd1, 6'h00, 1, 0, 0, 2'd2, 0}; // sll r1,r5,4
        vt[5] = '{32'hACA50004, 32'h1234, 32'h00000004, 5'd5, 6'h2B, 0, 0, 1, 2'd1, 0}; // sw r5,4(r5)
        vt[6] = '{32'h3C038000, 32'h0,    32'h00008000, 5'd3, 6'h0F, 1, 0, 0, 2'd1, 0}; // lui r3,0x8000

        // Reset held 3 cycles with a valid instruction offered
        set_idle();
        s_rst = 1'b0; s_iv = 1'b1; s_instr = 32'h00A00820;
        for (int i = 0; i < 3; i++) begin
            d_ready_exp = 0;
            cycle();
            chk("reset_outputs", {136'(sample()), bus.StallCount}, '0);
        end

        // Write r5 = 0x1234, then the vector table
        set_idle();
        s_we = 1'b1; s_wa = 5'd5; s_wd = 32'h1234;
        cycle();
        for (int i = 0; i < 7; i++) begin
            set_idle();
            s_iv = 1'b1; s_instr = vt[i].instr;
            cycle();
            chk($sformatf("vec%0d", i),
                {bus.out_valid, bus.ReadData1, bus.Immediate_Extended, bus.Rd, bus.ALUOp,
                 bus.RegWrite, bus.MemRead, bus.MemWrite, bus.ALUSrc, bus.Illegal},
                {1'b1, vt[i].rd1, vt[i].imm, vt[i].rd, vt[i].aluop,
                 vt[i].rw, vt[i].mr, vt[i].mw, vt[i].src, vt[i].ill});
        end

        // Load-use: lw r3,0(r0) ; add r4,r3,r3
        set_idle(); s_iv = 1'b1; s_instr = 32'h8C030000; d_ready_exp = 1;
        cycle();
        chk("lw_out", {bus.out_valid, bus.MemRead, bus.Rd}, {1'b1, 1'b1, 5'd3});
        s_instr = 32'h00632020; d_ready_exp = 0;
        cycle();
        chk("bubble", {bus.out_valid, bus.StallCount}, {1'b0, 16'd1});
        d_ready_exp = 1;
        cycle();
        chk("add_after_bubble", {bus.out_valid, bus.Rd, bus.ALUOp, bus.Rs, bus.Rt, bus.StallCount},
            {1'b1, 5'd4, 6'h20, 5'd3, 5'd3, 16'd1});

        // Back-pressure for 4 cycles
        s_ordy = 1'b0; s_instr = 32'h2002FFFF;
        for (int i = 0; i < 4; i++) begin
            d_ready_exp = 0;
            cycle();
            chk("hold", {bus.out_valid, bus.Rd, bus.ALUOp}, {1'b1, 5'd4, 6'h20});
        end
        // Flush with in_valid=1 drops the instruction
        s_flush = 1'b1;
        cycle();
        chk("flush", {135'd0, bus.out_valid}, 136'd0);
        set_idle(); d_ready_exp = 1;
        cycle();
        chk("flush_dropped", {135'd0, bus.out_valid}, 136'd0);

        // Same-cycle write-back read of r7
        set_idle(); s_we = 1'b1; s_wa = 5'd7; s_wd = 32'h55;
        cycle();
        s_wd = 32'hAA; s_iv = 1'b1; s_instr = 32'h00E04020;
        cycle();
`ifdef ID_WB_BYPASS_EN
        chk("wb_same_cycle", 136'(bus.ReadData1), 136'(32'hAA));
`else
        chk("wb_same_cycle", 136'(bus.ReadData1), 136'(32'h55));
`endif
        s_we = 1'b0;
        cycle();
        chk("wb_next_cycle", 136'(bus.ReadData1), 136'(32'hAA));

        // Writes to r0 are ignored
        s_we = 1'b1; s_wa = 5'd0; s_wd = 32'hDEAD; s_instr = 32'h00004020;
        cycle();
        chk("r0_same_cycle", {bus.ReadData1, bus.ReadData2}, 64'd0);
        s_we = 1'b0;
        cycle();
        chk("r0_next_cycle", {bus.ReadData1, bus.ReadData2}, 64'd0);

        // Reset in the middle of a stall
        set_idle(); s_iv = 1'b1; s_instr = 32'h8C030000;
        cycle();
        s_instr = 32'h00632020; s_ordy = 1'b0; d_ready_exp = 0;
        cycle();
        chk("stall_held", {bus.out_valid, bus.MemRead, bus.StallCount}, {1'b1, 1'b1, 16'd2});
        s_rst = 1'b0; d_ready_exp = 0;
        cycle();
        chk("reset_in_stall", {bus.out_valid, bus.StallCount}, 17'd0);
        s_rst = 1'b1; s_ordy = 1'b1; d_ready_exp = 1;
        cycle();
        chk("accept_after_reset", {bus.out_valid, bus.Rd, bus.StallCount}, {1'b1, 5'd4, 16'd0});

        // Randomized phase against the reference model
        ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
        fns = '{6'h20, 6'h22, 6'h00, 6'h02, 6'h03, 6'h2A, 6'h24};
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] op;
            int unsigned k;
            k = $urandom_range(0, 12);
            if (k < 11) op = ops[k];
            else if (k == 11) op = 6'h23;
            else op = 6'($urandom_range(0, 63));
            s_instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom())};
            if (op == 6'h00) begin
                s_instr[15:11] = 5'($urandom_range(0, 7));
                s_instr[5:0]   = fns[$urandom_range(0, 6)];
            end
            s_rst   = ($urandom_range(0, 199) != 0);
            s_iv    = ($urandom_range(0, 3) != 0);
            s_ordy  = ($urandom_range(0, 3) != 0);
            s_flush = ($urandom_range(0, 15) == 0);
            s_we    = 1'($urandom_range(0, 1));
            s_wa    = 5'($urandom_range(0, 7));
            s_wd    = $urandom();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
